// File: rtl/sdr_arb_16_pkg.sv
// Shared definitions for the SDRAM front-end arbiter: refresh default,
// pending counter width and arbiter state encoding.
package sdr_arb_16_pkg;

    localparam int REFRESH_INTERVAL_DEF = 390;
    localparam int PEND_W               = 4;

    typedef enum logic [1:0] {
        ARB  = 2'b00,
        GNT  = 2'b01,
        BUSY = 2'b10
    } arb_state_e;

endpackage

// File: rtl/sdr_refresh_timer.sv
// Periodic refresh tick plus a saturating count of refreshes not yet
// acknowledged by the command FSM; refresh_ovf latches a lost tick.
module sdr_refresh_timer
    import sdr_arb_16_pkg::*;
#(
    parameter int refresh_interval = REFRESH_INTERVAL_DEF,
    parameter int max_postponed    = 8
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic              cmd_aref_i,
    output logic [PEND_W-1:0] pending_o,
    output logic              refresh_ovf_o
);

    localparam int                TW     = $clog2(refresh_interval);
    localparam logic [TW-1:0]     RELOAD = TW'(refresh_interval - 1);
    localparam logic [PEND_W-1:0] PMAX   = PEND_W'(max_postponed);

    logic [TW-1:0]     timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              tick;

    always_comb begin
        tick    = (timer_q == '0);
        timer_d = tick ? RELOAD : timer_q - 1'b1;
        pend_d  = pend_q;
        // A tick arriving on a full counter is a refresh that can never be issued.
        ovf_d   = ovf_q | (tick && (pend_q == PMAX));
        if (tick && !cmd_aref_i && (pend_q != PMAX))
            pend_d = pend_q + 1'b1;
        else if (!tick && cmd_aref_i && (pend_q != '0))
            pend_d = pend_q - 1'b1;
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            timer_q <= RELOAD;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pending_o     = pend_q;
    assign refresh_ovf_o = ovf_q;

endmodule

// File: rtl/sdr_arb_16.sv
// Round-robin arbiter sharing the SDRAM command FSM between ingress FIFO
// ports, with refresh requests always served ahead of new grants.
module sdr_arb_16
    import sdr_arb_16_pkg::*;
#(
    parameter int nr_of_ports      = 4,
    parameter int refresh_interval = REFRESH_INTERVAL_DEF,
    parameter int max_postponed    = 8
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst,
    input  logic [nr_of_ports-1:0] port_empty,
    input  logic                   state_idle,
    input  logic                   cmd_aref,
    output logic [nr_of_ports-1:0] fifo_sel,
    output logic                   fifo_empty,
    output logic                   refresh_req,
    output logic                   refresh_ovf
);

    localparam int LW = (nr_of_ports > 1) ? $clog2(nr_of_ports) : 1;

    arb_state_e             state_q, state_d;
    logic [nr_of_ports-1:0] sel_q, sel_d;
    logic [LW-1:0]          last_q, last_d, winner;
    logic [PEND_W-1:0]      pending;

    // First requester after 'last', wrapping; scanned backwards so the nearest wins.
    function automatic logic [LW-1:0] rr_pick(input logic [nr_of_ports-1:0] req,
                                              input logic [LW-1:0]          last);
        int idx;
        rr_pick = last;
        for (int k = nr_of_ports; k >= 1; k--) begin
            idx = (int'(last) + k) % nr_of_ports;
            if (req[idx]) rr_pick = idx[LW-1:0];
        end
    endfunction

    sdr_refresh_timer #(
        .refresh_interval(refresh_interval),
        .max_postponed   (max_postponed)
    ) u_refresh (
        .sdram_clk    (sdram_clk),
        .sdram_rst    (sdram_rst),
        .cmd_aref_i   (cmd_aref),
        .pending_o    (pending),
        .refresh_ovf_o(refresh_ovf)
    );

    always_comb begin
        winner  = rr_pick(~port_empty, last_q);
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ARB: begin
                if (state_idle && (pending == '0) && (|(~port_empty))) begin
                    state_d        = GNT;
                    sel_d          = '0;
                    sel_d[winner]  = 1'b1;
                    last_d         = winner;
                end
            end
            GNT:     state_d = BUSY;
            BUSY:    if (state_idle) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_q <= ARB;
            sel_q   <= '0;
            last_q  <= LW'(nr_of_ports - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign fifo_sel    = sel_q;
    assign fifo_empty  = (state_q == ARB) ? 1'b1 : |(port_empty & sel_q);
    // Masking in GNT keeps a refresh and a grant from reaching the FSM together.
    assign refresh_req = (pending != '0) && (state_q != GNT);

endmodule

// File: tb/tb_sdr_arb_16.sv
// Directed and randomized checks of sdr_arb_16 against a cycle-level
// behavioural model of grants and refresh bookkeeping.
module tb_sdr_arb_16;

    localparam int N    = 4;
    localparam int RI   = 390;
    localparam int MAXP = 8;

    logic         sdram_clk = 1'b0;
    logic         sdram_rst = 1'b1;
    logic [N-1:0] port_empty = '1;
    logic         state_idle = 1'b0;
    logic         cmd_aref   = 1'b0;
    logic [N-1:0] fifo_sel;
    logic         fifo_empty, refresh_req, refresh_ovf;

    int checks = 0;
    int failures = 0;

    // behavioural model
    int m_cyc, m_pend, m_last, m_sel;
    bit m_ovf, m_gnt, m_busy;

    sdr_arb_16 #(.nr_of_ports(N), .refresh_interval(RI), .max_postponed(MAXP)) dut (
        .sdram_clk  (sdram_clk),
        .sdram_rst  (sdram_rst),
        .port_empty (port_empty),
        .state_idle (state_idle),
        .cmd_aref   (cmd_aref),
        .fifo_sel   (fifo_sel),
        .fifo_empty (fifo_empty),
        .refresh_req(refresh_req),
        .refresh_ovf(refresh_ovf)
    );

    always #5 sdram_clk = ~sdram_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_cyc = 0; m_pend = 0; m_last = N - 1; m_sel = -1;
        m_ovf = 0; m_gnt = 0; m_busy = 0;
    endtask

    function automatic logic [N-1:0] exp_sel();
        return (m_sel < 0) ? '0 : (N'(1) << m_sel);
    endfunction

    function automatic logic exp_empty();
        if (!m_gnt && !m_busy) return 1'b1;
        return (m_sel < 0) ? 1'b0 : port_empty[m_sel];
    endfunction

    function automatic logic exp_req();
        return (m_pend != 0) && !m_gnt;
    endfunction

    task automatic rst_checks(input string tag);
        chk({tag, "_sel"},   fifo_sel,    '0);
        chk({tag, "_empty"}, fifo_empty,  1'b1);
        chk({tag, "_req"},   refresh_req, 1'b0);
        chk({tag, "_ovf"},   refresh_ovf, 1'b0);
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        bit tk;
        int p0, w, idx;
        @(posedge sdram_clk);
        tk = (m_cyc % RI) == RI - 1;
        p0 = m_pend;
        if (tk && p0 == MAXP) m_ovf = 1;
        if (tk && !cmd_aref && p0 < MAXP) m_pend++;
        else if (!tk && cmd_aref && p0 > 0) m_pend--;
        if (m_gnt) begin
            m_gnt = 0; m_busy = 1;
        end else if (m_busy) begin
            if (state_idle) m_busy = 0;
        end else if (state_idle && p0 == 0 && port_empty != '1) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (w < 0 && !port_empty[idx]) w = idx;
            end
            m_sel = w; m_last = w; m_gnt = 1;
        end
        m_cyc++;
        #1;
        chk("sel",   fifo_sel,    exp_sel());
        chk("empty", fifo_empty,  exp_empty());
        chk("req",   refresh_req, exp_req());
        chk("ovf",   refresh_ovf, m_ovf);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input string tag);
        #3 sdram_rst = 1'b1;
        #1 rst_checks(tag);
        mreset();
        cmd_aref = 1'b0;
        @(posedge sdram_clk);
        @(negedge sdram_clk);
        sdram_rst = 1'b0;
    endtask

    // FSM stub: acknowledge refreshes one at a time until the request drops.
    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 30 && refresh_req; i++) begin
            cmd_aref = 1'b1; step();
            cmd_aref = 1'b0; step();
            n++;
        end
    endtask

    int cnt;
    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        mreset();
        #1 rst_checks("rst0");
        @(negedge sdram_clk);
        sdram_rst = 1'b0;

        // refresh request after one interval, nothing to grant
        state_idle = 1'b1;
        run(RI - 1);
        chk("req_before_tick", refresh_req, 1'b0);
        step();
        chk("req_at_tick", refresh_req, 1'b1);
        cmd_aref = 1'b1; step(); cmd_aref = 1'b0;
        chk("req_after_ack", refresh_req, 1'b0);
        chk("no_grant_idle", fifo_sel, '0);

        // single port grant, BUSY hold
        port_empty = 4'b1110;
        step();
        chk("gnt_sel", fifo_sel, 4'b0001);
        chk("gnt_empty", fifo_empty, 1'b0);
        state_idle = 1'b0;
        run(5);
        chk("busy_sel_held", fifo_sel, 4'b0001);
        state_idle = 1'b1;
        port_empty = 4'b1111;
        step();
        chk("back_arb_empty", fifo_empty, 1'b1);
        chk("arb_sel_held", fifo_sel, 4'b0001);

        // round-robin order with all ports requesting
        do_reset("rst_rr");
        port_empty = '0;
        for (int t = 0; t < 5; t++) begin
            state_idle = 1'b1; step();
            chk("rr_order", fifo_sel, N'(1) << order[t]);
            state_idle = 1'b0; run(3);
            state_idle = 1'b1; step();
        end

        // three refreshes postponed during BUSY
        do_reset("rst_p3");
        port_empty = 4'b1110; state_idle = 1'b1;
        step();
        state_idle = 1'b0;
        run(3 * RI);
        chk("p3_req", refresh_req, 1'b1);
        state_idle = 1'b1;
        step();
        drain(cnt);
        chk("p3_acks", cnt, 3);
        step();
        chk("p3_regrant", fifo_sel, 4'b0001);

        // saturation and sticky overflow
        do_reset("rst_p9");
        port_empty = 4'b1101; state_idle = 1'b1;
        step();
        state_idle = 1'b0;
        run(9 * RI);
        chk("ovf_set", refresh_ovf, 1'b1);
        state_idle = 1'b1;
        step();
        drain(cnt);
        chk("sat_acks", cnt, MAXP);
        run(3);
        chk("ovf_sticky", refresh_ovf, 1'b1);

        // ack coincident with a tick leaves pending unchanged
        do_reset("rst_coin");
        port_empty = 4'b1011; state_idle = 1'b1;
        step();
        state_idle = 1'b0;
        run(2 * RI);
        while ((m_cyc % RI) != RI - 1) step();
        cmd_aref = 1'b1; step(); cmd_aref = 1'b0;
        run(4);
        state_idle = 1'b1;
        step();
        drain(cnt);
        chk("coin_acks", cnt, 2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            port_empty = N'($urandom);
            state_idle = ($urandom_range(0, 3) != 0);
            cmd_aref   = refresh_req && state_idle && ($urandom_range(0, 2) == 0);
            step();
        end
        cmd_aref = 1'b0;

        // reset while BUSY
        port_empty = 4'b0111; state_idle = 1'b1;
        for (int i = 0; i < 20 && !(m_busy && !state_idle); i++) begin
            if (m_gnt) state_idle = 1'b0;
            step();
        end
        chk("busy_before_rst", fifo_empty, port_empty[m_sel < 0 ? 0 : m_sel]);
        do_reset("rst_busy");
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
